// File: rtl/down_counter18.sv
// Down counter with modulus MAXV+1, synchronous load with clamping, one-shot or
// auto-reload wrap, a terminal-count pulse, a done handshake and a decimal split
// of the count value.
module down_counter18 #(
  parameter int unsigned MAXV = 17
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       ld,
  input  logic [4:0] data,
  input  logic       en,
  input  logic       mode,
  input  logic       ack,
  output logic [4:0] counter,
  output logic       tc,
  output logic       busy,
  output logic       done,
  output logic       tens,
  output logic [3:0] ones
);

  localparam logic [4:0] MaxCnt = 5'(MAXV);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0] state_q, state_d;
  logic [4:0] counter_d;
  logic       tc_d;
  logic       done_d;
  logic [4:0] load_val;

  // Clamp the load value so the count can never exceed MAXV.
  always_comb begin
    load_val = (data > MaxCnt) ? MaxCnt : data;
  end

  // Next-state logic; load overrides every state, tc is a single-cycle pulse.
  always_comb begin
    state_d   = state_q;
    counter_d = counter;
    tc_d      = 1'b0;
    done_d    = done;
    if (ld) begin
      state_d   = StRun;
      counter_d = load_val;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Idle ignores en and ack; only a load restarts counting.
        end
        StRun: begin
          if (en) begin
            if (counter != 5'd0) begin
              counter_d = counter - 5'd1;
            end else if (mode) begin
              // mode is only looked at here, so mid-count changes hit the next wrap.
              counter_d = MaxCnt;
              tc_d      = 1'b1;
            end else begin
              state_d = StDone;
              done_d  = 1'b1;
              tc_d    = 1'b1;
            end
          end
        end
        StDone: begin
          if (ack) begin
            state_d = StIdle;
            done_d  = 1'b0;
          end
        end
        default: begin
          // Unreachable encoding: recover to idle.
          state_d = StIdle;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= StIdle;
      counter <= 5'd0;
      tc      <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      counter <= counter_d;
      tc      <= tc_d;
      done    <= done_d;
    end
  end

  // Status and decimal digit outputs decoded from registered state.
  always_comb begin
    busy = (state_q == StRun);
    tens = (counter >= 5'd10);
    ones = tens ? 4'(counter - 5'd10) : counter[3:0];
  end

endmodule

// File: tb/tb_down_counter18.sv
// Scoreboard bench for down_counter18: the stimulus process pushes the expected
// outputs for each checked cycle, the monitor pops and compares them.
module tb_down_counter18;

  logic       clk;
  logic       clr;
  logic       ld;
  logic [4:0] data;
  logic       en;
  logic       mode;
  logic       ack;
  logic [4:0] counter;
  logic       tc;
  logic       busy;
  logic       done;
  logic       tens;
  logic [3:0] ones;

  typedef struct {
    string      nm;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  event chk_ev;

  down_counter18 #(.MAXV(17)) dut (
    .clk    (clk),
    .clr    (clr),
    .ld     (ld),
    .data   (data),
    .en     (en),
    .mode   (mode),
    .ack    (ack),
    .counter(counter),
    .tc     (tc),
    .busy   (busy),
    .done   (done),
    .tens   (tens),
    .ones   (ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output vector {counter, tc, busy, done, tens, ones}.
  function automatic logic [12:0] pack(input int c, input logic t, input logic b,
                                       input logic dn);
    logic       tn;
    logic [3:0] on;
    tn = (c / 10) != 0;
    on = 4'(c % 10);
    return {5'(c), t, b, dn, tn, on};
  endfunction

  task automatic push(input string nm, input int c, input logic t, input logic b,
                      input logic dn);
    exp_t e;
    e.nm = nm;
    e.v  = pack(c, t, b, dn);
    q.push_back(e);
  endtask

  // Drive one cycle of inputs after the falling edge; optionally expect the
  // outputs that follow the next rising edge.
  task automatic cyc(input logic c, input logic l, input int d, input logic e,
                     input logic m, input logic a, input bit chk, input string nm,
                     input int ec, input logic et, input logic eb, input logic ed);
    @(negedge clk);
    #1;
    clr  = c;
    ld   = l;
    data = 5'(d);
    en   = e;
    mode = m;
    ack  = a;
    if (chk) push(nm, ec, et, eb, ed);
  endtask

  // Monitor: compares at each falling edge, or immediately on an async check.
  initial begin
    exp_t        e;
    logic [12:0] got;
    forever begin
      @(negedge clk or chk_ev);
      if (q.size() > 0) begin
        e   = q.pop_front();
        got = {counter, tc, busy, done, tens, ones};
        n_checks++;
        if (got !== e.v) begin
          n_fail++;
          $display("FAIL %s: got cnt=%0d tc=%b busy=%b done=%b tens=%b ones=%0d, expected cnt=%0d tc=%b busy=%b done=%b tens=%b ones=%0d",
                   e.nm, got[12:8], got[7], got[6], got[5], got[4], got[3:0],
                   e.v[12:8], e.v[7], e.v[6], e.v[5], e.v[4], e.v[3:0]);
        end
      end
    end
  end

  // Stimulus (args: clr ld data en mode ack chk name | cnt tc busy done).
  initial begin
    clr = 1'b1; ld = 1'b0; data = 5'd0; en = 1'b0; mode = 1'b0; ack = 1'b0;

    cyc(1, 0, 0, 0, 0, 0, 1, "reset",        0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "idle_en",      0, 0, 0, 0);

    // Reset-then-load, one-shot.
    cyc(0, 1, 5, 1, 0, 0, 1, "load5",        5, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "dec4",         4, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "dec3",         3, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "dec2",         2, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "dec1",         1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "dec0",         0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "oneshot_tc",   0, 1, 0, 1);

    // Done handshake.
    cyc(0, 0, 0, 1, 0, 0, 1, "done_hold1",   0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1, "done_hold2",   0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0, 1, "done_hold3",   0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1, 1, "ack_idle",     0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "idle_no_run",  0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 1, 1, "idle_ack",     0, 0, 0, 0);

    // Auto-reload.
    cyc(0, 1, 2, 1, 1, 0, 1, "load2",        2, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "ar1",          1, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "ar0",          0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "ar_wrap17",   17, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "ar16",        16, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 1, 1, "run_ack",     15, 0, 1, 0);

    // Mode only matters at the zero crossing.
    cyc(0, 1, 1, 1, 1, 0, 1, "load1_m1",     1, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "m1_to0",       0, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "mode_late",    0, 1, 0, 1);

    // Clamping and decimal split.
    cyc(0, 1, 25, 0, 0, 0, 1, "clamp25",    17, 0, 1, 0);
    cyc(0, 1, 18, 0, 0, 0, 1, "clamp18",    17, 0, 1, 0);
    cyc(0, 1, 10, 0, 0, 0, 1, "load10",     10, 0, 1, 0);
    cyc(0, 1, 9, 0, 0, 0, 1,  "load9",       9, 0, 1, 0);

    // Enable gating.
    cyc(0, 0, 0, 1, 0, 0, 1, "to8",          8, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, "en_hold8", 8, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "en_resume7",   7, 0, 1, 0);

    // Load beats the zero crossing.
    cyc(0, 1, 1, 1, 0, 0, 1, "load1",        1, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "at0",          0, 0, 1, 0);
    cyc(0, 1, 12, 1, 0, 0, 1, "ld_prio",    12, 0, 1, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "dec11",       11, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, "",             0, 0, 0, 0);

    // Asynchronous clear mid-cycle at counter 11.
    #1;
    push("pre_clr11", 11, 0, 1, 0);
    ->chk_ev;
    #1;
    clr = 1'b1;
    #1;
    push("async_clr", 0, 0, 0, 0);
    ->chk_ev;

    // After clear, en alone must not start counting.
    cyc(0, 0, 0, 1, 0, 0, 1, "clr_no_run",   0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 1, "clr_no_run2",  0, 0, 0, 0);

    // Load zero in auto-reload: immediate wrap.
    cyc(0, 1, 0, 1, 1, 0, 1, "load0",        0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "wrap_at0",    17, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 1, "after_wrap",  16, 0, 1, 0);

    // Drain the scoreboard.
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of stimulus, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/down_counter18.md
DOWN_COUNTER18 -- requirements
Module: down_counter18

Interface
REQ-001 SHALL have parameter MAXV, default 17, meaning the highest count value; modulus is MAXV+1 = 18.
REQ-002 SHALL have port clk  input  1  clock; all state changes on the rising edge.
REQ-003 SHALL have port clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ld  input  1  synchronous load, active-high.
REQ-005 SHALL have port data  input  5  load value.
REQ-006 SHALL have port en  input  1  count enable while running.
REQ-007 SHALL have port mode  input  1  1 = auto-reload at wrap, 0 = one-shot.
REQ-008 SHALL have port ack  input  1  acknowledges done.
REQ-009 SHALL have port counter  output  5  current count value (registered).
REQ-010 SHALL have port tc  output  1  terminal-count pulse (registered).
REQ-011 SHALL have port busy  output  1  high while in RUN.
REQ-012 SHALL have port done  output  1  one-shot completion flag (registered).
REQ-013 SHALL have port tens  output  1  decimal tens digit of counter (0 or 1).
REQ-014 SHALL have port ones  output  4  decimal ones digit of counter (0..9).

Function
REQ-015 SHALL implement a state machine with states IDLE, RUN and DONE.
REQ-016 SHALL apply priority clr > ld > all other behaviour.
REQ-017 SHALL, when ld=1, set counter to data if data<=MAXV, else to MAXV (clamp), and enter RUN with done=0 and tc=0, from any state.
REQ-018 SHALL, in RUN with en=1 and counter>0, decrement counter by 1 per clock.
REQ-019 SHALL, in RUN with en=0, hold counter and state; tc=0.
REQ-020 SHALL, in RUN with en=1, counter=0 and mode=1, reload counter to MAXV, stay in RUN, and assert tc for exactly one cycle.
REQ-021 SHALL, in RUN with en=1, counter=0 and mode=0, hold counter at 0, enter DONE, set done=1, and assert tc for exactly one cycle.
REQ-022 SHALL, in DONE, hold counter and done=1 until ack=1, then enter IDLE with done=0 on that edge.
REQ-023 SHALL, in IDLE, hold counter and ignore en and ack.
REQ-024 SHALL drive tc=0 on every cycle not covered by REQ-020/REQ-021; back-to-back tc is only possible with mode=1 and MAXV=0.
REQ-025 SHALL sample mode only at the zero-crossing edge, so a change of mode mid-count affects only the next wrap.
REQ-026 SHALL drive busy = (state==RUN) combinationally from the state register.
REQ-027 SHALL drive tens=1 and ones=counter-10 when counter>=10, else tens=0 and ones=counter; combinational, with no glitch-free requirement.
REQ-028 SHALL never let counter exceed MAXV under any input sequence.
REQ-029 SHALL, when ack=1 outside DONE, have no effect.

Reset
REQ-030 SHALL, while clr=1, force state=IDLE, counter=0, tc=0 and done=0 immediately, independent of clk.
REQ-031 SHALL, when clr deasserts mid-count, remain in IDLE until the next ld=1; en alone SHALL NOT start counting.

Verification
REQ-032 SHALL verify reset-then-load: pulse clr, then ld=1 with data=5, en=1, mode=0 -> counter 5,4,3,2,1,0; one cycle later tc=1 for one cycle, done=1, busy=0.
REQ-033 SHALL verify auto-reload: ld with data=2, mode=1, en=1 -> counter 2,1,0,17,16; tc=1 only on the cycle counter shows 17.
REQ-034 SHALL verify clamping: ld with data=25 -> counter=17, tens=1, ones=7; ld with data=9 -> tens=0, ones=9.
REQ-035 SHALL verify the done handshake: in DONE, hold ack=0 for 3 cycles -> done stays 1 and counter stays 0; ack=1 -> IDLE, done=0; then en=1 -> counter stays 0.
REQ-036 SHALL verify priority: ld=1 at the same edge as the zero-crossing (counter=0, en=1) -> counter=data, tc=0, done=0; assert clr asynchronously mid-cycle at counter=11 -> counter=0 immediately.
REQ-037 SHALL verify enable gating: in RUN at counter=8, en=0 for 4 cycles -> counter holds at 8 and busy=1; en=1 -> counter 7.
